usb_in_fifo: RTL and testbench

- Byte FIFO that sits directly upstream of the usb core's IN data port (data_in / data_in_valid / data_strobe).
- User logic pushes bytes at any rate on the write side.
- The read side presents the head byte first-word-fall-through and pops one byte per data_strobe pulse from the usb core.
- Replaces ad-hoc hand-sequenced byte feeding with buffered, flow-controlled delivery; tracks level and sticky overflow/underflow errors.

---
 rtl/usb_pkg.sv | 5 +
 rtl/usb_fifo_mem.sv | 25 ++
 rtl/usb_in_fifo.sv | 71 +++++++
 tb/tb_usb_in_fifo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB byte-path constants.
package usb_pkg;
  localparam int USB_BYTE_W            = 8;
  localparam int IN_FIFO_DEPTH_DEFAULT = 16;
endpackage

// File: rtl/usb_fifo_mem.sv
// DEPTH x byte storage: synchronous write, asynchronous read, so it can map to distributed RAM.
module usb_fifo_mem
  import usb_pkg::*;
#(
  parameter int DEPTH = IN_FIFO_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [USB_BYTE_W-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [USB_BYTE_W-1:0] rdata
);

  // No reset on the array so it stays RAM-mappable.
  logic [USB_BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_in_fifo.sv
// First-word-fall-through byte FIFO feeding the usb core IN data port, with level and sticky error flags.
module usb_in_fifo
  import usb_pkg::*;
#(
  parameter int DEPTH = IN_FIFO_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk_48,
  input  logic                  rst,
  input  logic [USB_BYTE_W-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  input  logic                  flush,
  output logic [USB_BYTE_W-1:0] data_in,
  output logic                  data_in_valid,
  input  logic                  data_strobe,
  output logic [AW:0]           level,
  output logic                  overflow,
  output logic                  underflow
);

  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [AW:0]           level_next;
  logic [USB_BYTE_W-1:0] head;
  logic                  push, pop;

  // At full a concurrent pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign pop        = data_strobe & data_in_valid;
  assign push       = wr_en & (~full | pop);
  assign level_next = level + (AW+1)'(push) - (AW+1)'(pop);

  usb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk_48),
    .we    (push & ~flush & ~rst),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Gating keeps data_in at zero whenever nothing valid is held, including after reset.
  assign data_in = data_in_valid ? head : '0;

  always_ff @(posedge clk_48) begin
    if (rst || flush) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      full          <= 1'b0;
      data_in_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level         <= level_next;
      full          <= (level_next == (AW+1)'(DEPTH));
      data_in_valid <= (level_next != '0);
    end
  end

  // Error flags survive flush; only reset clears them.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full & ~pop)          overflow  <= 1'b1;
      if (data_strobe & ~data_in_valid) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_in_fifo.sv
// Directed self-checking bench for usb_in_fifo.
module tb_usb_in_fifo;

  logic       clk_48 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       full;
  logic       flush = 1'b0;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_strobe = 1'b0;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  usb_in_fifo #(.DEPTH(16)) dut (
    .clk_48        (clk_48),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .full          (full),
    .flush         (flush),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_strobe   (data_strobe),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #10 clk_48 = ~clk_48;

  // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic strobe();
    data_strobe = 1'b1;
    tick();
    data_strobe = 1'b0;
  endtask

  initial begin
    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    chk("rst_data_in", 32'(data_in), 32'h00);
    for (int c = 0; c < 10; c++) begin
      chk("idle_valid", 32'(data_in_valid), 0);
      chk("idle_level", 32'(level), 0);
      chk("idle_full",  32'(full), 0);
      chk("idle_ovf",   32'(overflow), 0);
      chk("idle_unf",   32'(underflow), 0);
      tick();
    end

    // Single byte: visible the cycle after the write, drops after strobe
    write_byte(8'h01);
    for (int c = 0; c < 4; c++) begin
      chk("single_data",  32'(data_in), 32'h01);
      chk("single_valid", 32'(data_in_valid), 1);
      chk("single_level", 32'(level), 1);
      tick();
    end
    strobe();
    chk("single_pop_valid", 32'(data_in_valid), 0);
    chk("single_pop_level", 32'(level), 0);

    // Fill, overflow, drain every third cycle
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    chk("fill_full",  32'(full), 1);
    chk("fill_level", 32'(level), 16);
    write_byte(8'hFF);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_level", 32'(level), 16);
    chk("ovf_head",  32'(data_in), 32'h01);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data",  32'(data_in), 32'(i));
      chk("drain_valid", 32'(data_in_valid), 1);
      strobe();
      tick(); tick();
    end
    chk("drain_valid_end", 32'(data_in_valid), 0);
    chk("drain_level_end", 32'(level), 0);
    chk("drain_full_end",  32'(full), 0);

    // Concurrent push and pop at full; clear overflow first
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
    chk("cc_full_pre", 32'(full), 1);
    wr_data = 8'hAA; wr_en = 1'b1; data_strobe = 1'b1;
    tick();
    wr_en = 1'b0; data_strobe = 1'b0;
    chk("cc_level", 32'(level), 16);
    chk("cc_full",  32'(full), 1);
    chk("cc_ovf",   32'(overflow), 0);
    for (int i = 1; i < 16; i++) begin
      chk("cc_drain", 32'(data_in), 32'h20 + 32'(i));
      strobe();
    end
    chk("cc_last",       32'(data_in), 32'hAA);
    chk("cc_last_valid", 32'(data_in_valid), 1);
    strobe();
    chk("cc_empty", 32'(data_in_valid), 0);

    // Strobe while empty
    strobe();
    chk("unf_flag",  32'(underflow), 1);
    chk("unf_level", 32'(level), 0);
    chk("unf_valid", 32'(data_in_valid), 0);
    write_byte(8'h02);
    chk("unf_next_data",  32'(data_in), 32'h02);
    chk("unf_next_valid", 32'(data_in_valid), 1);
    strobe();
    chk("unf_next_empty", 32'(level), 0);

    // Flush with simultaneous write
    for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
    chk("fl_level_pre", 32'(level), 5);
    chk("fl_head_pre",  32'(data_in), 32'h30);
    wr_data = 8'hEE; wr_en = 1'b1; flush = 1'b1;
    tick();
    wr_en = 1'b0; flush = 1'b0;
    chk("fl_level", 32'(level), 0);
    chk("fl_valid", 32'(data_in_valid), 0);
    chk("fl_unf_sticky", 32'(underflow), 1);
    tick();
    chk("fl_still_empty", 32'(level), 0);
    write_byte(8'h50);
    chk("fl_after_data", 32'(data_in), 32'h50);
    chk("fl_after_lvl",  32'(level), 1);
    strobe();

    // Reset mid-stream with simultaneous write
    for (int i = 0; i < 5; i++) write_byte(8'h40 + 8'(i));
    chk("rs_level_pre", 32'(level), 5);
    wr_data = 8'hEE; wr_en = 1'b1; rst = 1'b1;
    tick();
    wr_en = 1'b0; rst = 1'b0;
    chk("rs_level", 32'(level), 0);
    chk("rs_valid", 32'(data_in_valid), 0);
    chk("rs_data",  32'(data_in), 32'h00);
    chk("rs_unf",   32'(underflow), 0);
    chk("rs_ovf",   32'(overflow), 0);
    write_byte(8'h60);
    chk("rs_after_data", 32'(data_in), 32'h60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
